// File: rtl/mult_secuencial.sv
// Shift-add unsigned multiplier fed by the BCD-to-binary converter; WIDTH steps per product.
// Define SKIP_ZERO_EN to end CALC early once the remaining multiplier bits are all zero.
module mult_secuencial #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               error_in,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done,
  output logic               error_out
);

  // state | meaning
  // IDLE  | waiting for start; done is cleared here
  // CALC  | one shift-add step per clock
  // DONE  | product/error_out loaded, done pulsed on the way back to IDLE
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplr;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic               err_flag;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mplr_step;
  logic [CW-1:0]      count_step;
  logic               last_step;
  logic [2*WIDTH-1:0] acc_aligned;

  // The carry out of the upper-half add lands in sum's MSB and is shifted straight back into acc.
  always_comb begin
    sum        = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplr[0] ? {1'b0, mcand} : '0);
    acc_step   = {sum, acc[WIDTH-1:1]};
    mplr_step  = mplr >> 1;
    count_step = count + CW'(1);
`ifdef SKIP_ZERO_EN
    last_step   = (count_step == CW'(WIDTH)) || (mplr_step == '0);
    acc_aligned = acc >> (CW'(WIDTH) - count);
`else
    last_step   = (count_step == CW'(WIDTH));
    acc_aligned = acc;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mcand     <= '0;
      mplr      <= '0;
      acc       <= '0;
      count     <= '0;
      err_flag  <= 1'b0;
      product   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (error_in) begin
              product   <= '0;
              error_out <= 1'b1;
              err_flag  <= 1'b1;
              state     <= DONE;
            end else begin
              mcand    <= a;
              mplr     <= b;
              acc      <= '0;
              count    <= '0;
              err_flag <= 1'b0;
              busy     <= 1'b1;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          acc   <= acc_step;
          mplr  <= mplr_step;
          count <= count_step;
          if (last_step) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          product   <= err_flag ? '0 : acc_aligned;
          error_out <= err_flag;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_secuencial.sv
// Directed bench for mult_secuencial: scoreboard of expected product/error/latency per operation.
module tb_mult_secuencial;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           error_in;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;
  logic           error_out;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2*W-1:0] prod;
    logic           err;
    int             lat;
    int             calc;
  } exp_t;

  exp_t sb[$];

  mult_secuencial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .error_in(error_in), .a(a), .b(b),
    .product(product), .busy(busy), .done(done), .error_out(error_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is first seen (or on timeout).
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ev,
                        input bit ghost);
    exp_t x;
    exp_t y;
    int   calc;
    int   e;
    calc = W;
`ifdef SKIP_ZERO_EN
    calc = 1;
    for (int i = 0; i < W; i++) if (bv[i]) calc = i + 1;
`endif
    x.prod = ev ? '0 : (2*W)'(av) * (2*W)'(bv);
    x.err  = ev;
    x.lat  = ev ? 1 : calc + 1;
    x.calc = ev ? 0 : calc;
    sb.push_back(x);
    a = av; b = bv; error_in = ev; start = 1'b1;
    @(negedge clk);
    start = 1'b0; error_in = 1'b0;
    check("done_one_cycle", done, 0);
    e = 0;
    while (!done && e < 40) begin
      check("busy", busy, (e < x.calc) ? 1 : 0);
      if (e == 1) begin a = W'($urandom); b = W'($urandom); end
      if (ghost && e == 2) begin a = 7; b = 7; start = 1'b1; end
      if (ghost && e == 3) start = 1'b0;
      @(negedge clk);
      e++;
    end
    y = sb.pop_front();
    check("latency", e, y.lat);
    check("product", product, y.prod);
    check("error_out", error_out, y.err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; error_in = 1'b0; a = '0; b = '0;
    #12;
    check("rst_product", product, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error_out", error_out, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op(8'd12, 8'd34, 1'b0, 1'b0);
    run_op(8'd99, 8'd99, 1'b0, 1'b0);
    run_op(8'd255, 8'd255, 1'b0, 1'b0);
    run_op(8'd0, 8'd57, 1'b0, 1'b0);
    run_op(8'd12, 8'd34, 1'b1, 1'b0);
    run_op(8'd3, 8'd5, 1'b0, 1'b0);
    run_op(8'd12, 8'd34, 1'b0, 1'b1);
    run_op(8'd7, 8'd7, 1'b0, 1'b0);

    // Abort 12*34 mid-CALC; previous product (49) must vanish at once.
    a = 8'd12; b = 8'd34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_product", product, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_error_out", error_out, 0);
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    run_op(8'd3, 8'd5, 1'b0, 1'b0);

    run_op(8'd3, 8'd2, 1'b0, 1'b0);
    run_op(8'd5, 8'd0, 1'b0, 1'b0);
    run_op(8'd1, 8'd128, 1'b0, 1'b0);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
